// File: rtl/phy_rx_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : phy_rx_flow_ctrl
// Description : Threshold flagging, upstream pause and round-robin egress
//               scheduling for the four PHY RX lane FIFOs.
//               Optional macro PHY_RX_PROG_UMBRAL_EN enables programmable
//               thresholds in INIT.
// Revision    : 1.0 - initial release
// ============================================================================
module phy_rx_flow_ctrl #(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 3
) (
    input  logic                            clk_f,
    input  logic                            reset,
    input  logic                            init,
    input  logic [ADDR_W:0]                 umbral_hi_in,
    input  logic [ADDR_W:0]                 umbral_lo_in,
    input  logic [NUM_LANES*(ADDR_W+1)-1:0] fifo_count,
    input  logic [NUM_LANES-1:0]            fifo_empty,
    input  logic [NUM_LANES-1:0]            fifo_full,
    input  logic [NUM_LANES-1:0]            fifo_push,
    input  logic                            egress_ready,
    output logic [NUM_LANES-1:0]            fifo_pop,
    output logic [1:0]                      egress_sel,
    output logic                            egress_valid,
    output logic [NUM_LANES-1:0]            almost_full,
    output logic [NUM_LANES-1:0]            almost_empty,
    output logic                            pause,
    output logic [ADDR_W:0]                 umbral_hi,
    output logic [ADDR_W:0]                 umbral_lo,
    output logic [4:0]                      state,
    output logic                            idle_out,
    output logic                            error_out
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] C_HI_RST = CW'(6);
    localparam logic [CW-1:0] C_LO_RST = CW'(1);

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_rr_ptr;
    logic [1:0]             r_sel;
    logic                   r_valid;
    logic [NUM_LANES-1:0]   r_af;
    logic [NUM_LANES-1:0]   r_ae;
    logic [NUM_LANES-1:0]   w_af_nxt;
    logic [NUM_LANES-1:0]   w_ae_nxt;
    logic [NUM_LANES-1:0]   w_pop;
    logic                   w_grant;
    logic [1:0]             w_grant_idx;
    logic                   w_overflow;

    assign w_overflow = |(fifo_push & fifo_full);

`ifdef PHY_RX_PROG_UMBRAL_EN
    localparam logic [CW-1:0] C_DEPTH = CW'(1 << ADDR_W);

    logic [CW-1:0] r_umbral_hi;
    logic [CW-1:0] r_umbral_lo;
    logic          w_cand_ok;

    assign w_cand_ok = (umbral_lo_in != '0) && (umbral_lo_in < umbral_hi_in)
                       && (umbral_hi_in <= C_DEPTH);

    always_ff @(posedge clk_f) begin
        if (reset) begin
            r_umbral_hi <= C_HI_RST;
            r_umbral_lo <= C_LO_RST;
        end else if (r_state == S_INIT && init && w_cand_ok) begin
            r_umbral_hi <= umbral_hi_in;
            r_umbral_lo <= umbral_lo_in;
        end
    end

    assign umbral_hi = r_umbral_hi;
    assign umbral_lo = r_umbral_lo;
`else
    logic w_unused_umbral;
    assign w_unused_umbral = ^{umbral_hi_in, umbral_lo_in};
    assign umbral_hi       = C_HI_RST;
    assign umbral_lo       = C_LO_RST;
`endif

    // Search starts one past the last grant; k == NUM_LANES wraps to the pointer itself.
    always_comb begin
        logic [1:0] cand;
        w_grant     = 1'b0;
        w_grant_idx = r_rr_ptr;
        w_pop       = '0;
        cand        = r_rr_ptr;
        if (r_state == S_ACTIVE && egress_ready) begin
            for (int k = 1; k <= NUM_LANES; k++) begin
                cand = r_rr_ptr + 2'(k);
                if (!w_grant && !fifo_empty[cand]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = cand;
                end
            end
        end
        if (w_grant) begin
            w_pop[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RESET:  w_state_nxt = S_INIT;
            S_INIT:   w_state_nxt = init ? S_INIT : S_IDLE;
            S_IDLE: begin
                if (init) begin
                    w_state_nxt = S_INIT;
                end else if (!(&fifo_empty)) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if ((&fifo_empty) && !w_grant) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERROR:  w_state_nxt = S_ERROR;
            default:  w_state_nxt = S_ERROR;
        endcase
        if (w_overflow && r_state != S_RESET) begin
            w_state_nxt = S_ERROR;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_flags
        assign w_af_nxt[i] = fifo_count[i*CW +: CW] >= umbral_hi;
        assign w_ae_nxt[i] = fifo_count[i*CW +: CW] <= umbral_lo;
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            r_state  <= S_RESET;
            r_rr_ptr <= 2'd3;
            r_sel    <= 2'd0;
            r_valid  <= 1'b0;
            r_af     <= '0;
            r_ae     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_grant;
            if (w_grant) begin
                r_rr_ptr <= w_grant_idx;
                r_sel    <= w_grant_idx;
            end
            if (r_state != S_RESET) begin
                r_af <= w_af_nxt;
                r_ae <= w_ae_nxt;
            end
        end
    end

    // Selection follows a live grant, otherwise holds the last lane for the read-latency cycle.
    assign fifo_pop     = w_pop;
    assign egress_sel   = w_grant ? w_grant_idx : r_sel;
    assign egress_valid = r_valid;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign pause        = (r_state == S_ERROR) || (|r_af);
    assign state        = r_state;
    assign idle_out     = (r_state == S_IDLE);
    assign error_out    = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_phy_rx_flow_ctrl
// Description : Directed vector table, corner sequences and randomized
//               model comparison for phy_rx_flow_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_rx_flow_ctrl;

`ifdef PHY_RX_PROG_UMBRAL_EN
    localparam logic [3:0] E_HI = 4'd5;
    localparam logic [3:0] E_LO = 4'd2;
`else
    localparam logic [3:0] E_HI = 4'd6;
    localparam logic [3:0] E_LO = 4'd1;
`endif

    logic        clk_f = 1'b0;
    logic        reset, init, egress_ready;
    logic [3:0]  umbral_hi_in, umbral_lo_in;
    logic [15:0] fifo_count;
    logic [3:0]  fifo_empty, fifo_full, fifo_push;
    logic [3:0]  fifo_pop, almost_full, almost_empty, umbral_hi, umbral_lo;
    logic [1:0]  egress_sel;
    logic        egress_valid, pause, idle_out, error_out;
    logic [4:0]  state;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_f = ~clk_f;

    phy_rx_flow_ctrl dut (
        .clk_f        (clk_f),
        .reset        (reset),
        .init         (init),
        .umbral_hi_in (umbral_hi_in),
        .umbral_lo_in (umbral_lo_in),
        .fifo_count   (fifo_count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_push    (fifo_push),
        .egress_ready (egress_ready),
        .fifo_pop     (fifo_pop),
        .egress_sel   (egress_sel),
        .egress_valid (egress_valid),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .pause        (pause),
        .umbral_hi    (umbral_hi),
        .umbral_lo    (umbral_lo),
        .state        (state),
        .idle_out     (idle_out),
        .error_out    (error_out)
    );

    typedef struct {
        logic rst, ini; logic [3:0] hi_in, lo_in; logic [15:0] cnt;
        logic [3:0] emp, ful, psh; logic rdy;
        logic [4:0] e_st; logic [3:0] e_pop; logic [1:0] e_sel; logic e_val;
        logic [3:0] e_af, e_ae; logic e_pause; logic [3:0] e_hi, e_lo;
    } vec_t;

    function automatic vec_t mk(logic rst, logic ini, logic [3:0] hi, logic [3:0] lo,
                                logic [15:0] cnt, logic [3:0] emp, logic [3:0] ful,
                                logic [3:0] psh, logic rdy, logic [4:0] st,
                                logic [3:0] pop, logic [1:0] sel, logic val,
                                logic [3:0] af, logic [3:0] ae, logic pz,
                                logic [3:0] ehi, logic [3:0] elo);
        vec_t v;
        v.rst = rst; v.ini = ini; v.hi_in = hi; v.lo_in = lo; v.cnt = cnt;
        v.emp = emp; v.ful = ful; v.psh = psh; v.rdy = rdy;
        v.e_st = st; v.e_pop = pop; v.e_sel = sel; v.e_val = val;
        v.e_af = af; v.e_ae = ae; v.e_pause = pz; v.e_hi = ehi; v.e_lo = elo;
        return v;
    endfunction

    // Reference model: state index 0..4 = RESET, INIT, IDLE, ACTIVE, ERROR
    int         m_st, m_hi, m_lo, m_ptr, m_sel;
    bit         m_val;
    bit [3:0]   m_af, m_ae;

    function automatic int grant_of();
        if (m_st != 3 || !egress_ready) return -1;
        for (int k = 1; k <= 4; k++) begin
            int l = (m_ptr + k) % 4;
            if (!fifo_empty[l]) return l;
        end
        return -1;
    endfunction

    task automatic model_update();
        int g, nxt, c;
        if (reset) begin
            m_st = 0; m_hi = 6; m_lo = 1; m_ptr = 3; m_sel = 0;
            m_val = 0; m_af = 0; m_ae = 0;
            return;
        end
        g = grant_of();
        if (m_st != 0) begin
            for (int i = 0; i < 4; i++) begin
                c = int'(fifo_count[4*i +: 4]);
                m_af[i] = (c >= m_hi);
                m_ae[i] = (c <= m_lo);
            end
        end
        m_val = (g >= 0);
        if (g >= 0) begin m_ptr = g; m_sel = g; end
`ifdef PHY_RX_PROG_UMBRAL_EN
        if (m_st == 1 && init && umbral_lo_in > 0 && umbral_lo_in < umbral_hi_in
            && umbral_hi_in <= 8) begin
            m_hi = int'(umbral_hi_in); m_lo = int'(umbral_lo_in);
        end
`endif
        if (m_st == 0)                          nxt = 1;
        else if (m_st == 4)                     nxt = 4;
        else if ((fifo_push & fifo_full) != 0)  nxt = 4;
        else if (m_st == 1)                     nxt = init ? 1 : 2;
        else if (m_st == 2)                     nxt = init ? 1 : ((fifo_empty != 4'hF) ? 3 : 2);
        else                                    nxt = (fifo_empty == 4'hF && g < 0) ? 2 : 3;
        m_st = nxt;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all(string tag, logic [4:0] st, logic [3:0] pop, logic [1:0] sel,
                           logic val, logic [3:0] af, logic [3:0] ae, logic pz,
                           logic [3:0] hi, logic [3:0] lo);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".pop"}, 32'(fifo_pop), 32'(pop));
        if (pop != 0 || val) chk({tag, ".sel"}, 32'(egress_sel), 32'(sel));
        chk({tag, ".valid"}, 32'(egress_valid), 32'(val));
        chk({tag, ".af"}, 32'(almost_full), 32'(af));
        chk({tag, ".ae"}, 32'(almost_empty), 32'(ae));
        chk({tag, ".pause"}, 32'(pause), 32'(pz));
        chk({tag, ".hi"}, 32'(umbral_hi), 32'(hi));
        chk({tag, ".lo"}, 32'(umbral_lo), 32'(lo));
        chk({tag, ".idle"}, 32'(idle_out), 32'(st == 5'b00100));
        chk({tag, ".err"}, 32'(error_out), 32'(st == 5'b10000));
    endtask

    // One clock: sample mid-cycle against the model, then advance model and clock.
    task automatic mcycle(string tag);
        int g;
        #4;
        g = grant_of();
        cmp_all(tag, 5'(1 << m_st), (g >= 0) ? 4'(1 << g) : 4'h0,
                (g >= 0) ? 2'(g) : 2'(m_sel), m_val, m_af, m_ae,
                (m_st == 4) || (m_af != 0), 4'(m_hi), 4'(m_lo));
        model_update();
        @(posedge clk_f); #1;
    endtask

    task automatic drive(logic rst, logic ini, logic [3:0] hi, logic [3:0] lo,
                         logic [15:0] cnt, logic [3:0] emp, logic [3:0] ful,
                         logic [3:0] psh, logic rdy);
        reset = rst; init = ini; umbral_hi_in = hi; umbral_lo_in = lo;
        fifo_count = cnt; fifo_empty = emp; fifo_full = ful; fifo_push = psh;
        egress_ready = rdy;
    endtask

    vec_t vt[21];

    initial begin
        vt[0]  = mk(0,0,0,0, 16'h0,    4'hF,0,0,0, 5'h01,4'h0,0,0, 4'h0,4'h0,0, 6,1);
        vt[1]  = mk(0,1,5,2, 16'h0,    4'hF,0,0,0, 5'h02,4'h0,0,0, 4'h0,4'h0,0, 6,1);
        vt[2]  = mk(0,1,5,2, 16'h0,    4'hF,0,0,0, 5'h02,4'h0,0,0, 4'h0,4'hF,0, E_HI,E_LO);
        vt[3]  = mk(0,0,3,4, 16'h0,    4'hF,0,0,0, 5'h02,4'h0,0,0, 4'h0,4'hF,0, E_HI,E_LO);
        vt[4]  = mk(0,1,3,4, 16'h0,    4'hF,0,0,0, 5'h04,4'h0,0,0, 4'h0,4'hF,0, E_HI,E_LO);
        vt[5]  = mk(0,1,3,4, 16'h0,    4'hF,0,0,0, 5'h02,4'h0,0,0, 4'h0,4'hF,0, E_HI,E_LO);
        vt[6]  = mk(0,0,3,4, 16'h0,    4'hF,0,0,0, 5'h02,4'h0,0,0, 4'h0,4'hF,0, E_HI,E_LO);
        vt[7]  = mk(0,0,0,0, 16'h3303, 4'h2,0,0,1, 5'h04,4'h0,0,0, 4'h0,4'hF,0, E_HI,E_LO);
        vt[8]  = mk(0,0,0,0, 16'h3303, 4'h2,0,0,1, 5'h08,4'h1,0,0, 4'h0,4'h2,0, E_HI,E_LO);
        vt[9]  = mk(0,0,0,0, 16'h3303, 4'h2,0,0,1, 5'h08,4'h4,2,1, 4'h0,4'h2,0, E_HI,E_LO);
        vt[10] = mk(0,0,0,0, 16'h3303, 4'h2,0,0,1, 5'h08,4'h8,3,1, 4'h0,4'h2,0, E_HI,E_LO);
        vt[11] = mk(0,0,0,0, 16'h3303, 4'h2,0,0,1, 5'h08,4'h1,0,1, 4'h0,4'h2,0, E_HI,E_LO);
        vt[12] = mk(0,0,0,0, 16'h3303, 4'h2,0,0,0, 5'h08,4'h0,0,1, 4'h0,4'h2,0, E_HI,E_LO);
        vt[13] = mk(0,0,0,0, 16'h3303, 4'h2,0,0,0, 5'h08,4'h0,0,0, 4'h0,4'h2,0, E_HI,E_LO);
        vt[14] = mk(0,0,0,0, 16'h3303, 4'h2,0,0,1, 5'h08,4'h4,2,0, 4'h0,4'h2,0, E_HI,E_LO);
        vt[15] = mk(0,0,0,0, 16'h3363, 4'h0,0,0,0, 5'h08,4'h0,2,1, 4'h0,4'h2,0, E_HI,E_LO);
        vt[16] = mk(0,0,0,0, 16'h3313, 4'h0,0,0,0, 5'h08,4'h0,2,0, 4'h2,4'h0,1, E_HI,E_LO);
        vt[17] = mk(0,0,0,0, 16'h3313, 4'h0,0,0,0, 5'h08,4'h0,2,0, 4'h0,4'h2,0, E_HI,E_LO);
        vt[18] = mk(0,0,0,0, 16'h3313, 4'h0,4'h4,4'h4,0, 5'h08,4'h0,2,0, 4'h0,4'h2,0, E_HI,E_LO);
        vt[19] = mk(0,1,0,0, 16'h3313, 4'hF,0,0,1, 5'h10,4'h0,2,0, 4'h0,4'h2,1, E_HI,E_LO);
        vt[20] = mk(0,1,0,0, 16'h3313, 4'hF,0,0,1, 5'h10,4'h0,2,0, 4'h0,4'h2,1, E_HI,E_LO);

        drive(1,0,0,0, 16'h0, 4'hF,0,0,0);
        repeat (2) begin model_update(); @(posedge clk_f); #1; end

        for (int i = 0; i < 21; i++) begin
            drive(vt[i].rst, vt[i].ini, vt[i].hi_in, vt[i].lo_in, vt[i].cnt,
                  vt[i].emp, vt[i].ful, vt[i].psh, vt[i].rdy);
            #4;
            cmp_all($sformatf("vec%0d", i), vt[i].e_st, vt[i].e_pop, vt[i].e_sel,
                    vt[i].e_val, vt[i].e_af, vt[i].e_ae, vt[i].e_pause,
                    vt[i].e_hi, vt[i].e_lo);
            model_update();
            @(posedge clk_f); #1;
        end

        // Error is sticky until reset; then drain a single lane back to IDLE
        drive(1,0,0,0, 16'h0, 4'hF,0,0,1);       mcycle("rst_err");
        drive(0,0,0,0, 16'h0, 4'hF,0,0,1);       mcycle("drain_r");
        drive(0,0,0,0, 16'h0, 4'hF,0,0,1);       mcycle("drain_i");
        drive(0,0,0,0, 16'h0020, 4'hD,0,0,1);    mcycle("drain_d");
        drive(0,0,0,0, 16'h0020, 4'hD,0,0,1);    mcycle("drain_a1");
        drive(0,0,0,0, 16'h0010, 4'hD,0,0,1);    mcycle("drain_a2");
        drive(0,0,0,0, 16'h0000, 4'hF,0,0,1);    mcycle("drain_last");
        chk("drain_idle", 32'(state), 32'h04);

        // Reset in the middle of a burst drops the in-flight valid
        drive(0,0,0,0, 16'h4444, 4'h0,0,0,1);
        repeat (3) mcycle("burst");
        drive(1,0,0,0, 16'h4444, 4'h0,0,0,1);    mcycle("burst_rst");
        drive(0,0,0,0, 16'h4444, 4'h0,0,0,1);    mcycle("after_rst");
        chk("after_rst_sel", 32'(egress_sel), 32'h0);

        for (int n = 0; n < 2000; n++) begin
            logic [15:0] c;
            for (int l = 0; l < 4; l++) c[4*l +: 4] = 4'($urandom_range(0, 8));
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), c,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 79) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                  $urandom_range(0, 3) != 0);
            mcycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
